// File: rtl/regfile1.sv
// -----------------------------------------------------------------------------
// regfile1 -- four-entry by WIDTH-bit register file for the calculator datapath.
//
// It has one synchronous write port and one combinational read port. All four
// registers are also driven straight onto r_out0..r_out3 for debug and
// observation.
//
// Ports
//   q       out  WIDTH  read data, register[rsel] (combinational)
//   d       in   WIDTH  write data
//   rsel    in   2      read register index
//   wsel    in   2      write register index
//   we      in   1      write enable, active-high
//   ck      in   1      clock; writes happen on the rising edge
//   res     in   1      asynchronous active-high reset; clears all registers
//   r_out0  out  WIDTH  contents of register 0
//   r_out1  out  WIDTH  contents of register 1
//   r_out2  out  WIDTH  contents of register 2
//   r_out3  out  WIDTH  contents of register 3
//
// Build option
//   REGFILE1_BYPASS_EN  When this macro is defined, a write to the register
//                       being read forwards d to q in the same cycle. The
//                       r_outN outputs still show the stored value.
// -----------------------------------------------------------------------------
module regfile1 #(
  parameter int WIDTH = 16
) (
  output logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] d,
  input  logic [1:0]       rsel,
  input  logic [1:0]       wsel,
  input  logic             we,
  input  logic             ck,
  input  logic             res,
  output logic [WIDTH-1:0] r_out0,
  output logic [WIDTH-1:0] r_out1,
  output logic [WIDTH-1:0] r_out2,
  output logic [WIDTH-1:0] r_out3
);

  logic [WIDTH-1:0] reg_q [4];
  logic [WIDTH-1:0] reg_d [4];

  // Next-state decode. The case has no default branch that writes, so an
  // X/Z wsel matches no item in simulation and no register changes.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    for (int i = 0; i < 4; i++) reg_d[i] = reg_q[i];
    if (we) begin
      case (wsel)
        2'd0:    reg_d[0] = d;
        2'd1:    reg_d[1] = d;
        2'd2:    reg_d[2] = d;
        2'd3:    reg_d[3] = d;
        default: ;
      endcase
    end
  end

  // NOTE: this is a small flop bank and not a RAM macro, so resetting every
  // entry is cheap and gives a defined power-up state.
  always_ff @(posedge ck or posedge res) begin
    if (res) begin
      for (int i = 0; i < 4; i++) reg_q[i] <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments, so every flop
      // samples the values from before the edge.
      for (int i = 0; i < 4; i++) reg_q[i] <= reg_d[i];
    end
  end

  // Read mux. An unknown rsel drives all-X onto q so that a bad index is
  // visible in simulation.
  always_comb begin
    q = 'x;
    case (rsel)
      2'd0:    q = reg_q[0];
      2'd1:    q = reg_q[1];
      2'd2:    q = reg_q[2];
      2'd3:    q = reg_q[3];
      default: q = 'x;
    endcase
`ifdef REGFILE1_BYPASS_EN
    // Write-through forwarding: the value being written is visible on q
    // before the edge. Reset takes priority, so nothing is forwarded then.
    if (we && !res && (wsel == rsel)) q = d;
`endif
  end

  assign r_out0 = reg_q[0];
  assign r_out1 = reg_q[1];
  assign r_out2 = reg_q[2];
  assign r_out3 = reg_q[3];

endmodule

// File: tb/tb_regfile1.sv
// -----------------------------------------------------------------------------
// tb_regfile1 -- directed self-checking bench for regfile1 (WIDTH = 16).
// Inputs are driven a short time after the rising edge. Outputs are sampled
// between edges. Expected values are written out by hand at each step.
// -----------------------------------------------------------------------------
module tb_regfile1;

  localparam int W = 16;

  logic [W-1:0] q, d, r_out0, r_out1, r_out2, r_out3;
  logic [1:0]   rsel, wsel;
  logic         we, ck, res;

  int total = 0;
  int bad   = 0;

  regfile1 #(.WIDTH(W)) dut (
    .q      (q),
    .d      (d),
    .rsel   (rsel),
    .wsel   (wsel),
    .we     (we),
    .ck     (ck),
    .res    (res),
    .r_out0 (r_out0),
    .r_out1 (r_out1),
    .r_out2 (r_out2),
    .r_out3 (r_out3)
  );

  initial ck = 1'b0;
  always #5 ck = ~ck;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_regs(input string tag, input logic [W-1:0] e0, input logic [W-1:0] e1,
                            input logic [W-1:0] e2, input logic [W-1:0] e3);
    check({tag, ".r0"}, r_out0, e0);
    check({tag, ".r1"}, r_out1, e1);
    check({tag, ".r2"}, r_out2, e2);
    check({tag, ".r3"}, r_out3, e3);
  endtask

  // Advance past the next rising edge. Outputs have settled when it returns.
  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  initial begin
    // Reset held, with write inputs parked and an unknown wsel.
    res = 1'b1; we = 1'b0; d = 16'h4c55; wsel = 2'bxx; rsel = 2'd0;
    #10;
    check("rst.q", q, 16'h0000);
    check_regs("rst", '0, '0, '0, '0);

    // Release reset between edges. With we=0, nothing is written for 350 ns.
    #2 res = 1'b0;
    for (int i = 0; i < 35; i++) begin
      tick();
      check("idle.q", q, 16'h0000);
      check_regs("idle", '0, '0, '0, '0);
    end

    // Single write to register 2.
    we = 1'b1; wsel = 2'd2; d = 16'h4c55;
    tick();
    we = 1'b0;
    check_regs("w2", 16'h0000, 16'h0000, 16'h4c55, 16'h0000);
    rsel = 2'd2; #1;
    check("w2.q", q, 16'h4c55);

    // With we=0, all registers hold whatever d and wsel are.
    d = 16'hdead; wsel = 2'd0;
    tick();
    check_regs("hold", 16'h0000, 16'h0000, 16'h4c55, 16'h0000);

    // Successive writes of 1..4 to indices 0..3.
    we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wsel = 2'(i); d = 16'(i + 1);
      tick();
    end
    we = 1'b0;
    check_regs("seq", 16'h0001, 16'h0002, 16'h0003, 16'h0004);

    // Read sweep: q follows rsel in the same cycle.
    rsel = 2'd0; #1 check("rd0", q, 16'h0001);
    rsel = 2'd1; #1 check("rd1", q, 16'h0002);
    rsel = 2'd2; #1 check("rd2", q, 16'h0003);
    rsel = 2'd3; #1 check("rd3", q, 16'h0004);

    // Asynchronous reset mid-cycle clears the registers before the next edge.
    tick();
    #2 res = 1'b1;
    #1;
    check("ares.q", q, 16'h0000);
    check_regs("ares", '0, '0, '0, '0);

    // A write attempted while reset is held has no effect.
    we = 1'b1; wsel = 2'd1; d = 16'hffff; rsel = 2'd1;
    tick();
    check("rstwr.q", q, 16'h0000);
    check_regs("rstwr", '0, '0, '0, '0);

    // Release reset between edges. Writes resume from the next edge.
    #2 res = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wsel = 2'(i); d = 16'(i + 1);
      tick();
    end
    we = 1'b0;
    check_regs("resume", 16'h0001, 16'h0002, 16'h0003, 16'h0004);

    // Write and read the same register: old value (or forwarded d) before the
    // edge, new value after it.
    we = 1'b1; wsel = 2'd1; rsel = 2'd1; d = 16'hbeef;
    #1;
`ifdef REGFILE1_BYPASS_EN
    check("wr_same.pre.q", q, 16'hbeef);
`else
    check("wr_same.pre.q", q, 16'h0002);
`endif
    check("wr_same.pre.r1", r_out1, 16'h0002);
    tick();
    we = 1'b0;
    #1;
    check("wr_same.post.q", q, 16'hbeef);
    check_regs("wr_same.post", 16'h0001, 16'hbeef, 16'h0003, 16'h0004);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
